util_fifo_gearbox: RTL and testbench



---
 rtl/util_gearbox_pkg.sv | 51 +++++
 rtl/util_fifo_gearbox_ram.sv | 40 ++++
 rtl/util_fifo_gearbox.sv | 155 +++++++++++++++
 tb/tb_util_fifo_gearbox.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_gearbox_pkg.sv
// util_gearbox_pkg: helper functions used to size the width-converting FIFO.
// The widths G, WR, RD and the pointer width depend on module parameters, so the
// package exposes them as constant functions that the modules call for their localparams.
package util_gearbox_pkg;

    // Ceiling log2 that never returns 0, so a one-entry array still gets an address bit.
    function automatic int unsigned clog2_safe(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Narrow word width G = min(in, out).
    function automatic int unsigned gear_g(input int unsigned in_w, input int unsigned out_w);
        return (in_w < out_w) ? in_w : out_w;
    endfunction

    // Narrow words per input beat.
    function automatic int unsigned gear_wr(input int unsigned in_w, input int unsigned out_w);
        return in_w / gear_g(in_w, out_w);
    endfunction

    // Narrow words per output beat.
    function automatic int unsigned gear_rd(input int unsigned in_w, input int unsigned out_w);
        return out_w / gear_g(in_w, out_w);
    endfunction

    // Width ratio R = max/min.
    function automatic int unsigned gear_ratio(input int unsigned in_w, input int unsigned out_w);
        return (in_w > out_w) ? gear_wr(in_w, out_w) : gear_rd(in_w, out_w);
    endfunction

    // Wrap-around pointer width: one extra bit above the address to tell full from empty.
    function automatic int unsigned gear_ptr_w(input int unsigned depth);
        return clog2_safe(depth) + 1;
    endfunction

    // Legal when widths divide each other and DEPTH is a power of two holding whole wide beats.
    function automatic bit gear_params_ok(input int unsigned in_w, input int unsigned out_w,
                                          input int unsigned depth);
        if (in_w == 0 || out_w == 0 || depth == 0) return 1'b0;
        if ((in_w % out_w) != 0 && (out_w % in_w) != 0) return 1'b0;
        if ((depth & (depth - 1)) != 0) return 1'b0;
        if ((depth % gear_ratio(in_w, out_w)) != 0) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/util_fifo_gearbox_ram.sv
// util_gearbox_ram: G-bit x DEPTH storage with a WR-word write port and an RD-word
// combinational read port; both ports wrap modulo DEPTH.
module util_gearbox_ram
    import util_gearbox_pkg::*;
#(
    parameter int unsigned G     = 32,
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WR    = 4,
    parameter int unsigned RD    = 1
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [clog2_safe(DEPTH)-1:0]  waddr,
    input  logic [WR*G-1:0]               wdata,
    input  logic [clog2_safe(DEPTH)-1:0]  raddr,
    output logic [RD*G-1:0]               rdata
);

    localparam int unsigned AW = clog2_safe(DEPTH);

    logic [G-1:0] mem [DEPTH];

    // Write all WR slices of a beat, LSB slice at waddr; index arithmetic wraps in AW bits.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(WR); k++) begin
                mem[waddr + AW'(k)] <= wdata[k*G +: G];
            end
        end
    end

    // Gather RD consecutive words, slot 0 in the LSBs.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < int'(RD); k++) begin
            rdata[k*G +: G] = mem[raddr + AW'(k)];
        end
    end

endmodule

// File: rtl/util_fifo_gearbox.sv
// util_fifo_gearbox: width-converting FIFO (step-down, step-up or pass-through) with
// valid/ready on both sides, space-aware full, synchronous flush and FWFT output.
// Optional build macro UTIL_FIFO_GEARBOX_LAST_EN adds s_last / m_last / m_keep framing.
module util_fifo_gearbox
    import util_gearbox_pkg::*;
#(
    parameter int unsigned IN_WIDTH     = 128,
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned DEPTH        = 512,
    parameter int unsigned AFULL_THRESH = DEPTH - 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [IN_WIDTH-1:0]               s_data,
    input  logic                              s_valid,
    output logic                              s_ready,
    output logic [OUT_WIDTH-1:0]              m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [gear_ptr_w(DEPTH)-1:0]      dcnt,
    output logic                              almost_full
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
    ,
    input  logic                              s_last,
    output logic                              m_last,
    output logic [gear_rd(IN_WIDTH, OUT_WIDTH)-1:0] m_keep
`endif
);

    localparam int unsigned G     = gear_g(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned WR    = gear_wr(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned RD    = gear_rd(IN_WIDTH, OUT_WIDTH);
    localparam int unsigned AW    = clog2_safe(DEPTH);
    localparam int unsigned PTR_W = gear_ptr_w(DEPTH);

    // Refuse to elaborate an illegal width/depth combination.
    if (!gear_params_ok(IN_WIDTH, OUT_WIDTH, DEPTH)) begin : g_bad_params
        $error("util_fifo_gearbox: illegal IN_WIDTH/OUT_WIDTH/DEPTH combination");
    end

    logic [PTR_W-1:0] w_cnt;
    logic [PTR_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_cnt_nxt;
    logic [PTR_W-1:0] r_cnt_nxt;
    logic [PTR_W-1:0] dcnt_nxt;
    logic             wr_fire;
    logic             rd_fire;
    logic [RD*G-1:0]  rd_words;

    // Handshakes are void during flush so neither side sees a beat consumed.
    assign wr_fire = s_valid & s_ready & ~flush;
    assign rd_fire = m_valid & m_ready & ~flush;

    util_gearbox_ram #(
        .G     (G),
        .DEPTH (DEPTH),
        .WR    (WR),
        .RD    (RD)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (w_cnt[AW-1:0]),
        .wdata (s_data),
        .raddr (r_cnt[AW-1:0]),
        .rdata (rd_words)
    );

    // Next pointer values; a framed step-up beat rounds the write pointer to an RD boundary.
    always_comb begin
        w_cnt_nxt = w_cnt;
        r_cnt_nxt = r_cnt;
        if (flush) begin
            w_cnt_nxt = '0;
            r_cnt_nxt = '0;
        end else begin
            if (wr_fire) begin
                w_cnt_nxt = w_cnt + PTR_W'(WR);
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
                if (s_last && (RD > 1)) begin
                    w_cnt_nxt = (w_cnt + PTR_W'(RD)) & ~PTR_W'(RD - 1);
                end
`endif
            end
            if (rd_fire) begin
                r_cnt_nxt = r_cnt + PTR_W'(RD);
            end
        end
        dcnt_nxt = w_cnt_nxt - r_cnt_nxt;
    end

    // Pointers and status flags, all derived from the post-update occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt       <= '0;
            r_cnt       <= '0;
            dcnt        <= '0;
            s_ready     <= 1'b1;
            m_valid     <= 1'b0;
            almost_full <= 1'(AFULL_THRESH == 0);
        end else begin
            w_cnt       <= w_cnt_nxt;
            r_cnt       <= r_cnt_nxt;
            dcnt        <= dcnt_nxt;
            s_ready     <= (PTR_W'(DEPTH) - dcnt_nxt) >= PTR_W'(WR);
            m_valid     <= dcnt_nxt >= PTR_W'(RD);
            almost_full <= 32'(dcnt_nxt) >= AFULL_THRESH;
        end
    end

`ifdef UTIL_FIFO_GEARBOX_LAST_EN
    logic [WR-1:0] wr_flags;
    logic [RD-1:0] rd_flags;

    // The last flag belongs to the final narrow slice of a framed input beat.
    always_comb begin
        wr_flags = '0;
        wr_flags[WR-1] = s_last;
    end

    util_gearbox_ram #(
        .G     (1),
        .DEPTH (DEPTH),
        .WR    (WR),
        .RD    (RD)
    ) u_last_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (w_cnt[AW-1:0]),
        .wdata (wr_flags),
        .raddr (r_cnt[AW-1:0]),
        .rdata (rd_flags)
    );

    // Slots after the first flagged slot are padding: masked to zero and not kept.
    always_comb begin : p_keep
        logic seen;
        seen   = 1'b0;
        m_keep = '0;
        m_data = '0;
        for (int k = 0; k < int'(RD); k++) begin
            m_keep[k] = ~seen;
            if (!seen) begin
                m_data[k*G +: G] = rd_words[k*G +: G];
            end
            seen = seen | rd_flags[k];
        end
    end

    assign m_last = |rd_flags;
`else
    assign m_data = rd_words;
`endif

endmodule

// File: tb/tb_util_fifo_gearbox.sv
// tb_util_fifo_gearbox: directed bench for three gearbox configurations
// (128->32 deep, 128->32 shallow, 32->128 shallow).
module tb_util_fifo_gearbox;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    // 128 -> 32, DEPTH 512
    logic         a_flush, a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_afull;
    logic [127:0] a_s_data;
    logic [31:0]  a_m_data;
    logic [9:0]   a_dcnt;
    // 128 -> 32, DEPTH 16
    logic         b_flush, b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_afull;
    logic [127:0] b_s_data;
    logic [31:0]  b_m_data;
    logic [4:0]   b_dcnt;
    // 32 -> 128, DEPTH 16
    logic         c_flush, c_s_valid, c_s_ready, c_m_valid, c_m_ready, c_afull;
    logic [31:0]  c_s_data;
    logic [127:0] c_m_data;
    logic [4:0]   c_dcnt;
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
    logic         a_s_last, a_m_last, b_s_last, b_m_last, c_s_last, c_m_last;
    logic [0:0]   a_m_keep, b_m_keep;
    logic [3:0]   c_m_keep;
`endif

    util_fifo_gearbox #(.IN_WIDTH(128), .OUT_WIDTH(32), .DEPTH(512), .AFULL_THRESH(496)) u_dn512 (
        .clk(clk), .rst(rst), .flush(a_flush),
        .s_data(a_s_data), .s_valid(a_s_valid), .s_ready(a_s_ready),
        .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
        .dcnt(a_dcnt), .almost_full(a_afull)
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
        , .s_last(a_s_last), .m_last(a_m_last), .m_keep(a_m_keep)
`endif
    );

    util_fifo_gearbox #(.IN_WIDTH(128), .OUT_WIDTH(32), .DEPTH(16), .AFULL_THRESH(12)) u_dn16 (
        .clk(clk), .rst(rst), .flush(b_flush),
        .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
        .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
        .dcnt(b_dcnt), .almost_full(b_afull)
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
        , .s_last(b_s_last), .m_last(b_m_last), .m_keep(b_m_keep)
`endif
    );

    util_fifo_gearbox #(.IN_WIDTH(32), .OUT_WIDTH(128), .DEPTH(16), .AFULL_THRESH(12)) u_up (
        .clk(clk), .rst(rst), .flush(c_flush),
        .s_data(c_s_data), .s_valid(c_s_valid), .s_ready(c_s_ready),
        .m_data(c_m_data), .m_valid(c_m_valid), .m_ready(c_m_ready),
        .dcnt(c_dcnt), .almost_full(c_afull)
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
        , .s_last(c_s_last), .m_last(c_m_last), .m_keep(c_m_keep)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] beat4(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    logic [31:0]  exp_q[$];
    logic [31:0]  exp_w;
    logic [127:0] cur_beat;
    int sent, recv, cyc;

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        a_flush = 0; a_s_valid = 0; a_m_ready = 0; a_s_data = '0;
        b_flush = 0; b_s_valid = 0; b_m_ready = 0; b_s_data = '0;
        c_flush = 0; c_s_valid = 0; c_m_ready = 0; c_s_data = '0;
`ifdef UTIL_FIFO_GEARBOX_LAST_EN
        a_s_last = 0; b_s_last = 0; c_s_last = 0;
`endif
        @(negedge clk);
        tick();
        tick();

        // reset state
        check("rst_a_dcnt",  128'(a_dcnt),    128'(0));
        check("rst_a_sready",128'(a_s_ready), 128'(1));
        check("rst_a_mvalid",128'(a_m_valid), 128'(0));
        check("rst_a_afull", 128'(a_afull),   128'(0));
        check("rst_b_afull", 128'(b_afull),   128'(0));
        check("rst_c_mvalid",128'(c_m_valid), 128'(0));
        check("rst_c_sready",128'(c_s_ready), 128'(1));
        rst = 1'b0;
        tick();

        // step-down 128 -> 32
        a_s_data  = 128'h44444444_33333333_22222222_11111111;
        a_s_valid = 1;
        a_m_ready = 1;
        tick();
        a_s_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("dn_mvalid", 128'(a_m_valid), 128'(1));
            check("dn_data",   128'(a_m_data),  128'(32'h11111111 * (i + 1)));
            check("dn_dcnt",   128'(a_dcnt),    128'(4 - i));
            tick();
        end
        check("dn_empty_dcnt",   128'(a_dcnt),    128'(0));
        check("dn_empty_mvalid", 128'(a_m_valid), 128'(0));
        a_m_ready = 0;

        // step-up 32 -> 128
        c_s_valid = 1;
        c_s_data = 32'hA; tick();
        c_s_data = 32'hB; tick();
        c_s_data = 32'hC; tick();
        check("up_partial_mvalid", 128'(c_m_valid), 128'(0));
        check("up_partial_dcnt",   128'(c_dcnt),    128'(3));
        c_s_data = 32'hD; tick();
        c_s_valid = 0;
        check("up_full_mvalid", 128'(c_m_valid), 128'(1));
        check("up_full_data",   c_m_data, {32'hD, 32'hC, 32'hB, 32'hA});
        check("up_full_dcnt",   128'(c_dcnt),    128'(4));
        c_m_ready = 1; tick(); c_m_ready = 0;
        check("up_read_dcnt",   128'(c_dcnt),    128'(0));
        check("up_read_mvalid", 128'(c_m_valid), 128'(0));

        // full boundary, DEPTH 16
        for (int i = 0; i < 4; i++) begin
            b_s_data  = beat4(32'h1000 + 32'(4 * i));
            b_s_valid = 1;
            tick();
        end
        check("full_dcnt",   128'(b_dcnt),    128'(16));
        check("full_sready", 128'(b_s_ready), 128'(0));
        check("full_afull",  128'(b_afull),   128'(1));
        b_s_data = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
        tick();
        b_s_valid = 0;
        check("full_blocked_dcnt", 128'(b_dcnt), 128'(16));
        for (int j = 0; j < 16; j++) begin
            check("full_drain_data", 128'(b_m_data), 128'(32'h1000 + 32'(j)));
            b_m_ready = 1;
            tick();
            if (j == 0) begin
                check("one_read_dcnt",   128'(b_dcnt),    128'(15));
                check("one_read_sready", 128'(b_s_ready), 128'(0));
            end
            if (j == 3) begin
                check("four_read_dcnt",   128'(b_dcnt),    128'(12));
                check("four_read_sready", 128'(b_s_ready), 128'(1));
                check("four_read_afull",  128'(b_afull),   128'(1));
            end
            if (j == 4) begin
                check("five_read_afull", 128'(b_afull), 128'(0));
            end
        end
        b_m_ready = 0;
        check("drain_dcnt", 128'(b_dcnt), 128'(0));

        // streaming with wrap-around and simultaneous read/write
        sent = 0; recv = 0; cyc = 0;
        while ((recv < 400) && (cyc < 3000)) begin
            check("stream_dcnt", 128'(b_dcnt), 128'(exp_q.size()));
            b_s_valid = (sent < 100);
            cur_beat  = beat4(32'hB0000000 + 32'(4 * sent));
            b_s_data  = cur_beat;
            b_m_ready = 1'(cyc & 1);
            if (b_s_valid && b_s_ready) begin
                for (int k = 0; k < 4; k++) exp_q.push_back(cur_beat[k*32 +: 32]);
                sent++;
            end
            if (b_m_valid && b_m_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 128'(b_m_valid), 128'(0));
                end else begin
                    exp_w = exp_q.pop_front();
                    check("stream_data", 128'(b_m_data), 128'(exp_w));
                end
                recv++;
            end
            cyc++;
            tick();
        end
        b_s_valid = 0;
        b_m_ready = 0;
        check("stream_done", 128'(recv), 128'(400));
        check("stream_end_dcnt", 128'(b_dcnt), 128'(0));

        // flush with dcnt=8 and a concurrent write
        b_s_valid = 1;
        b_s_data = beat4(32'h2000); tick();
        b_s_data = beat4(32'h2004); tick();
        check("preflush_dcnt", 128'(b_dcnt), 128'(8));
        b_flush  = 1;
        b_s_data = beat4(32'h3000);
        tick();
        b_flush   = 0;
        b_s_valid = 0;
        check("flush_dcnt",   128'(b_dcnt),    128'(0));
        check("flush_mvalid", 128'(b_m_valid), 128'(0));
        check("flush_sready", 128'(b_s_ready), 128'(1));
        b_s_valid = 1;
        b_s_data  = beat4(32'h4000);
        tick();
        b_s_valid = 0;
        check("postflush_dcnt", 128'(b_dcnt), 128'(4));
        for (int j = 0; j < 4; j++) begin
            check("postflush_data", 128'(b_m_data), 128'(32'h4000 + 32'(j)));
            b_m_ready = 1;
            tick();
        end
        b_m_ready = 0;
        check("postflush_empty", 128'(b_m_valid), 128'(0));

        // reset with a partially collected step-up word
        c_s_valid = 1;
        c_s_data = 32'h5000; tick();
        c_s_data = 32'h5001; tick();
        c_s_valid = 0;
        check("midrst_pre_dcnt", 128'(c_dcnt), 128'(2));
        rst = 1; tick(); rst = 0;
        check("midrst_dcnt",   128'(c_dcnt),    128'(0));
        tick();
        check("midrst_mvalid", 128'(c_m_valid), 128'(0));
        c_s_valid = 1;
        for (int i = 0; i < 4; i++) begin
            c_s_data = 32'h6000 + 32'(i);
            tick();
        end
        c_s_valid = 0;
        check("midrst_new_mvalid", 128'(c_m_valid), 128'(1));
        check("midrst_new_data",   c_m_data, {32'h6003, 32'h6002, 32'h6001, 32'h6000});
        c_m_ready = 1; tick(); c_m_ready = 0;
        check("midrst_new_empty", 128'(c_dcnt), 128'(0));

`ifdef UTIL_FIFO_GEARBOX_LAST_EN
        // framed step-up: short frame is padded
        c_s_valid = 1;
        c_s_data = 32'h1; tick();
        c_s_data = 32'h2; c_s_last = 1; tick();
        c_s_valid = 0; c_s_last = 0;
        check("last_up_mvalid", 128'(c_m_valid), 128'(1));
        check("last_up_data",   c_m_data, {32'h0, 32'h0, 32'h2, 32'h1});
        check("last_up_keep",   128'(c_m_keep), 128'(4'b0011));
        check("last_up_last",   128'(c_m_last), 128'(1));
        check("last_up_dcnt",   128'(c_dcnt),   128'(4));
        c_m_ready = 1; tick(); c_m_ready = 0;
        check("last_up_read_dcnt", 128'(c_dcnt), 128'(0));
        // unframed full step-up beat
        c_s_valid = 1;
        for (int i = 0; i < 4; i++) begin
            c_s_data = 32'h7100 + 32'(i);
            tick();
        end
        c_s_valid = 0;
        check("nolast_up_keep", 128'(c_m_keep), 128'(4'b1111));
        check("nolast_up_last", 128'(c_m_last), 128'(0));
        c_m_ready = 1; tick(); c_m_ready = 0;
        // framed step-down
        b_s_valid = 1; b_s_last = 1;
        b_s_data  = beat4(32'h7000);
        tick();
        b_s_valid = 0; b_s_last = 0;
        for (int j = 0; j < 4; j++) begin
            check("last_dn_data", 128'(b_m_data), 128'(32'h7000 + 32'(j)));
            check("last_dn_last", 128'(b_m_last), 128'(j == 3));
            check("last_dn_keep", 128'(b_m_keep), 128'(1));
            b_m_ready = 1;
            tick();
        end
        b_m_ready = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
